// File: rtl/score_controller.sv
// Two-player score keeper: match FSM, per-player scores, one shared serial
// binary-to-BCD converter with round-robin arbitration, and a 4-digit display scan.
module score_controller #(
  parameter logic [4:0] WIN_SCORE    = 5'd15,
  parameter int         REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit_p1,
  input  logic       hit_p2,
  output logic [4:0] score_p1,
  output logic [4:0] score_p2,
  output logic [7:0] bcd_p1,
  output logic [7:0] bcd_p2,
  output logic       bcd_valid,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] digit_sel,
  output logic [3:0] digit_val
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t      state_q, state_d;
  logic [4:0]  score_p1_d, score_p2_d;
  logic [1:0]  winner_d;

  logic        dirty_p1, dirty_p2;
  logic        chg_p1, chg_p2;
  logic        grant_p1, grant_p2;
  logic        last_grant;            // 0 = P1 granted last, 1 = P2 granted last
  logic        conv_busy;
  logic        conv_sel;              // 0 = converting P1, 1 = converting P2
  logic [2:0]  conv_cnt;
  logic [12:0] conv_sr;               // {tens, units, remaining binary bits}
  logic [12:0] conv_step;

  logic [REFRESH_BITS-1:0] refresh_cnt, refresh_nxt;
  logic [1:0]              top_cur, top_nxt;

  // One double-dabble iteration: add 3 to any nibble >= 5, then shift left.
  function automatic logic [12:0] dd_step(input logic [12:0] s);
    logic [12:0] t;
    t = s;
    if (t[12:9] >= 4'd5) t[12:9] = t[12:9] + 4'd3;
    if (t[8:5]  >= 4'd5) t[8:5]  = t[8:5]  + 4'd3;
    return {t[11:0], 1'b0};
  endfunction

  // Match FSM and score next-state
  always_comb begin
    state_d    = state_q;
    score_p1_d = score_p1;
    score_p2_d = score_p2;
    winner_d   = winner;
    case (state_q)
      IDLE: begin
        if (start) state_d = PLAY;
      end
      PLAY: begin
        score_p1_d = score_p1 + {4'd0, hit_p1};
        score_p2_d = score_p2 + {4'd0, hit_p2};
        if ((score_p1_d == WIN_SCORE) || (score_p2_d == WIN_SCORE)) begin
          state_d  = OVER;
          winner_d = {score_p2_d == WIN_SCORE, score_p1_d == WIN_SCORE};
        end
      end
      OVER: begin
        if (start) begin
          state_d    = IDLE;
          score_p1_d = 5'd0;
          score_p2_d = 5'd0;
          winner_d   = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      score_p1 <= 5'd0;
      score_p2 <= 5'd0;
      winner   <= 2'b00;
    end else begin
      state_q  <= state_d;
      score_p1 <= score_p1_d;
      score_p2 <= score_p2_d;
      winner   <= winner_d;
    end
  end

  assign game_over = (state_q == OVER);

  // Arbitration only happens while the converter is idle; ties alternate.
  assign chg_p1    = (score_p1_d != score_p1);
  assign chg_p2    = (score_p2_d != score_p2);
  assign grant_p1  = ~conv_busy & dirty_p1 & (~dirty_p2 | last_grant);
  assign grant_p2  = ~conv_busy & dirty_p2 & (~dirty_p1 | ~last_grant);
  assign conv_step = dd_step(conv_sr);
  assign bcd_valid = ~dirty_p1 & ~dirty_p2 & ~conv_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_p1   <= 1'b0;
      dirty_p2   <= 1'b0;
      last_grant <= 1'b1;
      conv_busy  <= 1'b0;
      conv_sel   <= 1'b0;
      conv_cnt   <= 3'd0;
      conv_sr    <= 13'd0;
      bcd_p1     <= 8'd0;
      bcd_p2     <= 8'd0;
    end else begin
      // A score change on the grant edge re-arms the flag (set beats clear).
      dirty_p1 <= chg_p1 | (dirty_p1 & ~grant_p1);
      dirty_p2 <= chg_p2 | (dirty_p2 & ~grant_p2);
      if (grant_p1 || grant_p2) begin
        conv_busy  <= 1'b1;
        conv_sel   <= grant_p2;
        conv_cnt   <= 3'd0;
        conv_sr    <= {8'd0, grant_p2 ? score_p2 : score_p1};
        last_grant <= grant_p2;
      end else if (conv_busy) begin
        conv_sr  <= conv_step;
        conv_cnt <= conv_cnt + 3'd1;
        if (conv_cnt == 3'd4) begin
          conv_busy <= 1'b0;
          if (conv_sel) bcd_p2 <= conv_step[12:5];
          else          bcd_p1 <= conv_step[12:5];
        end
      end
    end
  end

  // Display scan: digit outputs load only when the counter's top two bits move.
  assign refresh_nxt = refresh_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
  assign top_cur     = refresh_cnt[REFRESH_BITS-1 -: 2];
  assign top_nxt     = refresh_nxt[REFRESH_BITS-1 -: 2];

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_sel   <= 4'b1110;
      digit_val   <= 4'd0;
    end else begin
      refresh_cnt <= refresh_nxt;
      if (top_nxt != top_cur) begin
        case (top_nxt)
          2'd0: begin digit_sel <= 4'b1110; digit_val <= bcd_p1[7:4]; end
          2'd1: begin digit_sel <= 4'b1101; digit_val <= bcd_p1[3:0]; end
          2'd2: begin digit_sel <= 4'b1011; digit_val <= bcd_p2[7:4]; end
          default: begin digit_sel <= 4'b0111; digit_val <= bcd_p2[3:0]; end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller: an FSM/score vector table on a WIN_SCORE=3
// instance plus hand-written conversion, tie, scan and reset sequences.
module tb_score_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, hit_p1 = 1'b0, hit_p2 = 1'b0;

  logic [4:0] score_p1, score_p2, s_score_p1, s_score_p2;
  logic [7:0] bcd_p1, bcd_p2, s_bcd_p1, s_bcd_p2;
  logic       bcd_valid, game_over, s_bcd_valid, s_game_over;
  logic [1:0] winner, s_winner;
  logic [3:0] digit_sel, digit_val, s_digit_sel, s_digit_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_controller #(.WIN_SCORE(5'd15), .REFRESH_BITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .hit_p1(hit_p1), .hit_p2(hit_p2),
    .score_p1(score_p1), .score_p2(score_p2), .bcd_p1(bcd_p1), .bcd_p2(bcd_p2),
    .bcd_valid(bcd_valid), .game_over(game_over), .winner(winner),
    .digit_sel(digit_sel), .digit_val(digit_val)
  );

  score_controller #(.WIN_SCORE(5'd3), .REFRESH_BITS(3)) dut_small (
    .clk(clk), .rst(rst), .start(start), .hit_p1(hit_p1), .hit_p2(hit_p2),
    .score_p1(s_score_p1), .score_p2(s_score_p2), .bcd_p1(s_bcd_p1), .bcd_p2(s_bcd_p2),
    .bcd_valid(s_bcd_valid), .game_over(s_game_over), .winner(s_winner),
    .digit_sel(s_digit_sel), .digit_val(s_digit_val)
  );

  typedef struct {
    logic       rst, start, h1, h2;
    logic [4:0] e1, e2;
    logic       go;
    logic [1:0] w;
  } vec_t;

  vec_t tbl[17];

  task automatic setv(input int i, input bit r, input bit s, input bit a, input bit b,
                      input int e1, input int e2, input bit go, input int w);
    tbl[i].rst = r;  tbl[i].start = s; tbl[i].h1 = a; tbl[i].h2 = b;
    tbl[i].e1 = 5'(e1); tbl[i].e2 = 5'(e2); tbl[i].go = go; tbl[i].w = 2'(w);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit s, input bit a, input bit b);
    rst = r; start = s; hit_p1 = a; hit_p2 = b;
    tick();
    rst = 1'b0; start = 1'b0; hit_p1 = 1'b0; hit_p2 = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bcd_valid && n < 40) begin
      tick();
      n++;
    end
    chk(name, 16'(bcd_valid), 16'd1);
  endtask

  task automatic hit_and_settle(input bit a, input bit b, input int reps);
    for (int i = 0; i < reps; i++) begin
      drive(1'b0, 1'b0, a, b);
      wait_valid("settle_valid");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_sel;
    logic [7:0] scan_exp[8];
    bit         found;

    // Table against the WIN_SCORE=3 instance: {rst,start,h1,h2} -> {s1,s2,go,winner}
    setv(0,  1,0,0,0, 0,0,0,0);
    setv(1,  0,0,1,0, 0,0,0,0);   // hit in IDLE ignored
    setv(2,  0,1,0,0, 0,0,0,0);   // IDLE -> PLAY
    setv(3,  0,0,1,0, 1,0,0,0);
    setv(4,  0,0,0,1, 1,1,0,0);
    setv(5,  0,1,0,0, 1,1,0,0);   // start in PLAY ignored
    setv(6,  0,0,1,1, 2,2,0,0);
    setv(7,  0,0,1,0, 3,2,1,1);   // P1 wins
    setv(8,  0,0,0,1, 3,2,1,1);   // hit in OVER ignored
    setv(9,  0,1,0,0, 0,0,0,0);   // OVER -> IDLE clears
    setv(10, 0,0,0,1, 0,0,0,0);
    setv(11, 0,1,0,0, 0,0,0,0);
    setv(12, 0,0,0,1, 0,1,0,0);
    setv(13, 0,0,0,1, 0,2,0,0);
    setv(14, 0,0,0,1, 0,3,1,2);   // P2 wins
    setv(15, 1,1,1,0, 0,0,0,0);   // reset beats start/hit
    setv(16, 0,0,1,0, 0,0,0,0);   // still IDLE after reset

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset state of the main instance
    chk("rst_score_p1", 16'(score_p1), 16'd0);
    chk("rst_score_p2", 16'(score_p2), 16'd0);
    chk("rst_bcd", 16'({bcd_p1, bcd_p2}), 16'h0000);
    chk("rst_bcd_valid", 16'(bcd_valid), 16'd1);
    chk("rst_game_over", 16'(game_over), 16'd0);
    chk("rst_winner", 16'(winner), 16'd0);
    chk("rst_digit", 16'({digit_sel, digit_val}), 16'({4'b1110, 4'd0}));

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].h1, tbl[i].h2);
      chk($sformatf("row%0d", i), 16'({s_score_p1, s_score_p2, s_game_over, s_winner}),
          16'({tbl[i].e1, tbl[i].e2, tbl[i].go, tbl[i].w}));
    end

    // Tie win on the WIN_SCORE=3 instance
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("tie_pre", 16'({s_score_p1, s_score_p2, s_game_over}), 16'({5'd2, 5'd2, 1'b0}));
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("tie_win", 16'({s_score_p1, s_score_p2, s_game_over, s_winner}),
        16'({5'd3, 5'd3, 1'b1, 2'b11}));
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("tie_hold", 16'({s_score_p1, s_score_p2, s_winner}), 16'({5'd3, 5'd3, 2'b11}));
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("tie_clear", 16'({s_score_p1, s_score_p2, s_game_over, s_winner}), 16'd0);
    chk("tie_clear_dirty", 16'(s_bcd_valid), 16'd0);

    // Single hit: conversion visible exactly 6 cycles after the grant cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("single_score", 16'(score_p1), 16'd1);
    chk("single_valid_low", 16'(bcd_valid), 16'd0);
    ticks(5);
    chk("single_g5", 16'({bcd_valid, bcd_p1}), 16'({1'b0, 8'h00}));
    tick();
    chk("single_g6", 16'({bcd_valid, bcd_p1}), 16'({1'b1, 8'h01}));

    // Simultaneous hits at 4/4: P1 first, P2 six cycles later
    hit_and_settle(1'b1, 1'b0, 3);
    hit_and_settle(1'b0, 1'b1, 4);
    chk("simul_pre", 16'({bcd_p1, bcd_p2}), 16'h0404);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("simul_scores", 16'({score_p1, score_p2}), 16'({5'd5, 5'd5}));
    ticks(6);
    chk("simul_p1_first", 16'({bcd_valid, bcd_p1, bcd_p2[3:0]}), 16'({1'b0, 8'h05, 4'h4}));
    ticks(5);
    chk("simul_p2_pending", 16'(bcd_p2), 16'h04);
    tick();
    chk("simul_p2_done", 16'({bcd_valid, bcd_p2}), 16'({1'b1, 8'h05}));

    // Hit during P1's 7->8 conversion forces a reconversion to 9
    hit_and_settle(1'b1, 1'b0, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("redo_score", 16'(score_p1), 16'd9);
    ticks(3);
    chk("redo_stale", 16'({bcd_valid, bcd_p1}), 16'({1'b0, 8'h08}));
    wait_valid("redo_valid");
    chk("redo_final", 16'(bcd_p1), 16'h09);

    // Display scan with P1=12, P2=7
    hit_and_settle(1'b1, 1'b0, 3);
    hit_and_settle(1'b0, 1'b1, 2);
    chk("scan_bcd", 16'({bcd_p1, bcd_p2}), 16'h1207);
    scan_exp = '{8'hE1, 8'hE1, 8'hD2, 8'hD2, 8'hB0, 8'hB0, 8'h77, 8'h77};
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev_sel = digit_sel;
      tick();
      if (prev_sel == 4'b0111 && digit_sel == 4'b1110) found = 1'b1;
    end
    chk("scan_sync", 16'(found), 16'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("scan%0d", i), 16'({digit_sel, digit_val}), 16'(scan_exp[i]));
      tick();
    end

    // Reset at G+3 of a conversion
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_scores", 16'({score_p1, score_p2}), 16'd0);
    chk("midrst_bcd", 16'({bcd_p1, bcd_p2}), 16'd0);
    chk("midrst_flags", 16'({bcd_valid, game_over, winner}), 16'({1'b1, 1'b0, 2'b00}));
    chk("midrst_digit", 16'({digit_sel, digit_val}), 16'({4'b1110, 4'd0}));
    ticks(8);
    chk("midrst_no_residual", 16'({bcd_valid, bcd_p1}), 16'({1'b1, 8'h00}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_controller.md
SCORE_CONTROLLER -- requirements
Module: score_controller

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5'd15, winning score; legal range 1..31.
REQ-002 SHALL have parameter REFRESH_BITS, default 16, width of the display refresh counter; minimum 3.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse; starts a match, or clears a finished match.
REQ-006 SHALL have ports hit_p1, hit_p2  input  1 each  one-cycle hit pulses, one per player.
REQ-007 SHALL have ports score_p1, score_p2  output  5 each  binary scores.
REQ-008 SHALL have ports bcd_p1, bcd_p2  output  8 each  {tens[3:0], units[3:0]}.
REQ-009 SHALL have port bcd_valid  output  1  high when both BCD outputs match the current scores.
REQ-010 SHALL have port game_over  output  1  high while in state OVER.
REQ-011 SHALL have port winner  output  2  encoding: 00 none, 01 P1, 10 P2, 11 tie.
REQ-012 SHALL have port digit_sel  output  4  active-low one-hot digit enable.
REQ-013 SHALL have port digit_val  output  4  BCD nibble for the enabled digit.

Function
REQ-014 Main FSM SHALL have three states, IDLE, PLAY and OVER, with these transitions:
- IDLE->PLAY on start.
- PLAY->OVER on the edge where either score becomes WIN_SCORE.
- OVER->IDLE on start.
REQ-015 Scores SHALL be cleared to 0 on entry to IDLE.
REQ-016 Scores SHALL change only in PLAY.
REQ-017 In PLAY, hit_pX SHALL increment score_pX by 1, registered, so the new value is visible on the next cycle.
REQ-018 Simultaneous hits SHALL increment both scores in the same cycle.
REQ-019 Hits in IDLE or OVER SHALL be ignored.
REQ-020 On the winning edge, winner SHALL be set as follows:
- 01 if only P1 reaches WIN_SCORE.
- 10 if only P2 reaches WIN_SCORE.
- 11 if both reach it on the same edge.
REQ-021 winner SHALL hold its value through OVER and SHALL clear to 00 on entry to IDLE.
REQ-022 start in PLAY SHALL be ignored.
REQ-023 The block SHALL have exactly one shared serial binary-to-BCD converter, using shift/add-3 over 5 score bits.
REQ-024 Each player SHALL have a dirty flag, set on any cycle that player's score register changes (increment or clear).
REQ-025 Arbiter behaviour when the converter is idle:
- With one flag dirty, it SHALL grant that player.
- With both dirty, it SHALL grant the player not granted last.
- last_grant SHALL reset to P2, so P1 wins the first tie.
REQ-026 Conversion timing:
- Grant cycle G: latch a score snapshot and clear the granted dirty flag.
- Cycles G+1..G+5: one shift/add-3 iteration per cycle, MSB first.
- bcd_pX SHALL update at the end of G+5.
- The converter SHALL be idle again at G+6, so the next grant can occur in G+6.
REQ-027 If a score changes during its own conversion, the dirty flag SHALL be set again; the running conversion SHALL complete with the stale snapshot and be followed by a reconversion.
REQ-028 If a dirty flag is set and cleared on the same edge, set SHALL win.
REQ-029 bcd_valid SHALL equal (both dirty flags clear) AND (converter idle).
REQ-030 BCD output ranges SHALL be tens 0..3 and units 0..9; a snapshot of 31 SHALL yield 8'h31.
REQ-031 A free-running refresh counter of REFRESH_BITS width SHALL wrap from all-ones to 0.
REQ-032 The top 2 counter bits SHALL select the displayed digit:
- 0: P1 tens, digit_sel 4'b1110.
- 1: P1 units, digit_sel 4'b1101.
- 2: P2 tens, digit_sel 4'b1011.
- 3: P2 units, digit_sel 4'b0111.
REQ-033 digit_val SHALL be the selected nibble of the bcd_pX registers.
REQ-034 digit_sel and digit_val SHALL be registered and SHALL change only when the top 2 counter bits change.

Reset
REQ-035 While rst is high at a clock edge, the following SHALL take effect on that edge:
- FSM goes to IDLE.
- Scores and bcd_p1/p2 are 0.
- Dirty flags are clear.
- Converter goes idle, aborting any conversion in progress.
- last_grant is P2.
- game_over is 0 and winner is 2'b00.
- Refresh counter is 0; digit_sel is 4'b1110; digit_val is 0.
- bcd_valid is 1.
REQ-036 rst asserted mid-match or mid-conversion SHALL produce exactly the state in REQ-035 on the next edge, with no residual pending conversion.
REQ-037 start or hit_pX asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-038 Scenario single hit: reset, start, one hit_p1 -> score_p1=1 next cycle; bcd_valid low; bcd_p1=8'h01 and bcd_valid high 6 cycles after grant.
REQ-039 Scenario simultaneous hits: with both scores at 4, pulse hit_p1 and hit_p2 together -> both scores become 5; P1 is converted first; P2 completes 6 cycles later; bcd_p2=8'h05.
REQ-040 Scenario tie win: WIN_SCORE=3, both scores at 2, simultaneous hits -> game_over=1, winner=2'b11; further hits leave scores at 3; start -> IDLE, scores 0, winner 00.
REQ-041 Scenario hit during conversion: hit_p1 while converting P1's 7->8 -> final bcd_p1 equals the new score 9 (8'h09) after reconversion, never stuck at 8'h08.
REQ-042 Scenario display scan: REFRESH_BITS=3, bcd_p1=8'h12, bcd_p2=8'h07 -> digit_sel/digit_val cycle 1110/1, 1101/2, 1011/0, 0111/7, each held 2 cycles.
REQ-043 Scenario reset mid-conversion: assert rst at G+3 -> all outputs match REQ-035 on the next edge, and bcd_p1 stays 0.
